data_compression_encoder: RTL
=============================

Name: data_compression_encoder

Overview:
Streaming compressor that feeds data_decompression. It learns a 4-entry codebook of distinct 6-bit symbols (c1..c4), each with a fixed 2-bit code (e1..e4). It then encodes 24-bit words (four 6-bit symbols) into 12-bit compressed words: bits [7:0] hold the codes and bits [11:8] hold per-symbol miss flags. It has a valid/ready handshake on both sides.

Parameters:
MISS_CNT_W, 16, width of saturating miss counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
load_cb  input  1  single-cycle pulse: clear codebook, enter LEARN
in_valid  input  1  input word valid
in_ready  output  1  input word accepted when in_valid && in_ready
in_data  input  24  symbols s0=[5:0], s1=[11:6], s2=[17:12], s3=[23:18]
out_valid  output  1  compressed word valid
out_ready  input  1  downstream accepts when out_valid && out_ready
out_data  output  12  [1:0]=code s0 .. [7:6]=code s3; [8+i]=miss flag for symbol i
c1, c2, c3, c4  output  6 each  codebook entries
e1, e2, e3, e4  output  2 each  constants 2'b00, 2'b01, 2'b10, 2'b11
cb_valid  output  1  codebook full; encoding active
miss_count  output  MISS_CNT_W  saturating count of unmatched symbols since last load_cb

Behaviour:
- Clock and reset: one clock (clk). Asynchronous active-high reset.
- Reset values: state=IDLE, c1..c4=0, fill=0, cb_valid=0, out_valid=0, out_data=0, miss_count=0, in_ready=0.
- States:
  - IDLE: in_ready=0. load_cb -> LEARN.
  - LEARN: in_ready=1. No output is produced.
    - Each accepted word is scanned s0 to s3 in order.
    - A symbol is inserted at entry index fill (c1 first) if it is not equal to any existing entry and not equal to any symbol already inserted from the same word.
    - Once fill reaches 4, the remaining symbols in that word are discarded.
    - When fill reaches 4: next state ENCODE and cb_valid=1 on the following edge.
  - ENCODE: in_ready = !out_valid || out_ready.
    - On accept, register out_data and set out_valid on the next edge. Latency is 1 cycle.
    - Symbol i matching entry k gives code e_k and miss flag 0.
    - A symbol with no match gives code 2'b00 and miss flag 1.
    - miss_count increments by the popcount of the miss flags and saturates at all-ones.
- Output handshake:
  - out_valid stays asserted and out_data stays stable until out_ready is seen.
  - Simultaneous consume and accept in the same cycle gives back-to-back output with no bubble.
- load_cb:
  - Honoured in any state. Clears c1..c4, fill, cb_valid and miss_count, and enters LEARN on the next edge.
  - An input word presented in the same cycle as load_cb is not accepted (in_ready is forced 0 that cycle).
  - A pending output word (out_valid=1) is still held and delivered normally. It is not discarded.
- Words with duplicate symbols during LEARN consume only one entry per distinct value.
- Reset asserted mid-operation aborts everything immediately, including any pending output.

Optional Feature:
Macro ENCODER_MISS_COUNT_EN.
- Defined: miss_count operates as described above.
- Undefined: miss_count is tied to 0, the counter logic is removed, and the miss flags in out_data[11:8] are still produced.

Test Plan:
- Reset, then check values: all outputs 0. Pulse load_cb, then send 0xFC5285 -> c1=0x05, c2=0x0A, c3=0x3F, fill=3, cb_valid=0, no out_valid.
- Continue LEARN with 0x451451 -> c4=0x11. cb_valid=1 one cycle later. State ENCODE.
- Encode 0x47F285 with out_ready=1 -> next cycle out_valid=1, out_data=0x0E4, miss_count=0.
- Encode 0x145160 -> out_data=0x100, miss_count=1. Then hold out_ready=0 for 3 cycles and present a new word -> in_ready=0, out_data stable at 0x100.
- Pulse load_cb while out_valid=1 and out_ready=0 -> pending 0x100 is still delivered when out_ready rises. cb_valid=0, miss_count=0, c1..c4=0, state LEARN.
- Assert reset during LEARN after 1 entry -> all outputs back to reset values. in_ready=0 until a new load_cb.

Source files
------------

// File: rtl/data_compression_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_compression_encoder_if
// Description : Input word stream and compressed output stream of the encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_compression_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;

  // master: the environment around the encoder; slave: the encoder itself
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/data_compression_encoder.sv
`default_nettype none
// ============================================================================
// Module      : data_compression_encoder
// Description : Learns a 4-entry codebook of 6-bit symbols, then packs each
//               24-bit word into 8 code bits plus 4 miss flags.
//               Optional miss counter: define ENCODER_MISS_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module data_compression_encoder #(
  parameter int MISS_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_cb,
  data_compression_encoder_if.slave stream,
  output logic [5:0]                c1,
  output logic [5:0]                c2,
  output logic [5:0]                c3,
  output logic [5:0]                c4,
  output logic [1:0]                e1,
  output logic [1:0]                e2,
  output logic [1:0]                e3,
  output logic [1:0]                e4,
  output logic                      cb_valid,
  output logic [MISS_CNT_W-1:0]     miss_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LEARN  = 2'd1,
    ST_ENCODE = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  cb [4];
  logic [2:0]  fill;
  logic        out_valid_q;
  logic [11:0] out_data_q;

  logic        in_ready_w;
  logic        in_accept;
  logic        enc_accept;

  logic [5:0]  learn_cb [4];
  logic [2:0]  learn_fill;
  logic        learn_hit;

  logic [11:0] enc_word;
  logic        enc_hit;
  logic [1:0]  enc_code;

  assign c1 = cb[0];
  assign c2 = cb[1];
  assign c3 = cb[2];
  assign c4 = cb[3];
  assign e1 = 2'b00;
  assign e2 = 2'b01;
  assign e3 = 2'b10;
  assign e4 = 2'b11;

  assign stream.in_ready  = in_ready_w;
  assign stream.out_valid = out_valid_q;
  assign stream.out_data  = out_data_q;

  // The cycle with fill==4 still in LEARN is the hand-over to ENCODE; hold off input then
  always_comb begin
    in_ready_w = 1'b0;
    if (!load_cb) begin
      case (state)
        ST_LEARN:  in_ready_w = (fill != 3'd4);
        ST_ENCODE: in_ready_w = !out_valid_q || stream.out_ready;
        default:   in_ready_w = 1'b0;
      endcase
    end
  end

  assign in_accept  = stream.in_valid && in_ready_w;
  assign enc_accept = in_accept && (state == ST_ENCODE);

  // Insert each new distinct symbol of the word in s0..s3 order until full
  always_comb begin
    learn_cb   = cb;
    learn_fill = fill;
    learn_hit  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      learn_hit = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if ((3'(k) < learn_fill) && (learn_cb[k] == stream.in_data[6*i +: 6]))
          learn_hit = 1'b1;
      end
      if (!learn_hit && (learn_fill != 3'd4)) begin
        learn_cb[learn_fill[1:0]] = stream.in_data[6*i +: 6];
        learn_fill                = learn_fill + 3'd1;
      end
    end
  end

  always_comb begin
    enc_word = '0;
    enc_hit  = 1'b0;
    enc_code = 2'b00;
    for (int i = 0; i < 4; i++) begin
      enc_hit  = 1'b0;
      enc_code = 2'b00;
      for (int k = 0; k < 4; k++) begin
        if (!enc_hit && (cb[k] == stream.in_data[6*i +: 6])) begin
          enc_hit  = 1'b1;
          enc_code = 2'(k);
        end
      end
      enc_word[2*i +: 2] = enc_code;
      enc_word[8 + i]    = !enc_hit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      for (int k = 0; k < 4; k++) cb[k] <= '0;
      fill        <= '0;
      cb_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // A pending output drains normally in every state, load_cb included
      if (enc_accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= enc_word;
      end else if (stream.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (load_cb) begin
        for (int k = 0; k < 4; k++) cb[k] <= '0;
        fill     <= '0;
        cb_valid <= 1'b0;
        state    <= ST_LEARN;
      end else begin
        case (state)
          ST_LEARN: begin
            if (fill == 3'd4) begin
              state    <= ST_ENCODE;
              cb_valid <= 1'b1;
            end else if (in_accept) begin
              cb   <= learn_cb;
              fill <= learn_fill;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ENCODER_MISS_COUNT_EN
  logic [MISS_CNT_W-1:0] miss_cnt;
  logic [2:0]            miss_pop;
  logic [MISS_CNT_W:0]   miss_sum;

  assign miss_pop = 3'(enc_word[8]) + 3'(enc_word[9]) + 3'(enc_word[10]) + 3'(enc_word[11]);
  assign miss_sum = {1'b0, miss_cnt} + (MISS_CNT_W+1)'(miss_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_cnt <= '0;
    end else if (load_cb) begin
      miss_cnt <= '0;
    end else if (enc_accept) begin
      miss_cnt <= miss_sum[MISS_CNT_W] ? '1 : miss_sum[MISS_CNT_W-1:0];
    end
  end

  assign miss_count = miss_cnt;
`else
  assign miss_count = '0;
`endif

endmodule
`default_nettype wire
